// File: rtl/tt_serial_adder_pkg.sv
// rtl/tt_serial_adder_pkg.sv - shared types and pin constants for the serial adder
package tt_serial_adder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int PIN_START = 0;
   localparam int PIN_MODE  = 1;
   localparam int PIN_CARRY = 4;
   localparam int PIN_BUSY  = 5;
   localparam int PIN_DONE  = 6;
   localparam int PIN_OVF   = 7;

   localparam int WIDTH_MAX = 4;

endpackage

// File: rtl/tt_serial_adder_if.sv
// rtl/tt_serial_adder_if.sv - tiny-tapeout style pin bundle for the serial adder
interface tt_serial_adder_if;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   modport master (output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
   modport slave  (input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/serial_fa_cell.sv
// rtl/serial_fa_cell.sv - combinational one-bit full adder
module serial_fa_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);
   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/tt_um_serial_adder.sv
// rtl/tt_um_serial_adder.sv - bit-serial add/subtract unit, LSB first
module tt_um_serial_adder
   import tt_serial_adder_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   tt_serial_adder_if.slave   bus
);
   if (WIDTH < 1 || WIDTH > WIDTH_MAX) begin : g_bad_width
      $error("tt_um_serial_adder: WIDTH must be in 1..4");
   end

   localparam int CW = $clog2(WIDTH + 1);

   state_t           state;
   state_t           state_nx;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] sreg;
   logic [WIDTH-1:0] sreg_nx;
   logic [WIDTH-1:0] res_q;
   logic             carry_q;
   logic             mode_q;
   logic             flag_q;
   logic             ovf_q;
   logic             start;
   logic             mode;
   logic             last;
   logic             fa_s;
   logic             fa_cout;
   logic             unused_in;

   assign start = bus.uio_in[PIN_START];
   assign mode  = bus.uio_in[PIN_MODE];
   assign last  = (cnt == CW'(WIDTH - 1));

   // Sum bit enters at the MSB; after WIDTH shifts the LSB has reached bit 0.
   assign sreg_nx = WIDTH'({fa_s, sreg} >> 1);

   serial_fa_cell u_fa (
      .a    (a_q[cnt]),
      .b    (b_q[cnt]),
      .cin  (carry_q),
      .s    (fa_s),
      .cout (fa_cout)
   );

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nx;
   end

   // Next-state: accept start when idle or done, finish after WIDTH enabled bits
   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE, ST_DONE: if (bus.ena && start) state_nx = ST_RUN;
         ST_RUN:           if (bus.ena && last)  state_nx = ST_DONE;
         default:          state_nx = ST_IDLE;
      endcase
   end

   // Datapath: operand capture, one full-adder bit per enabled RUN edge, result load
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sreg    <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         mode_q  <= 1'b0;
         flag_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (bus.ena) begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  a_q     <= bus.ui_in[WIDTH-1:0];
                  // Subtract is A + ~B + 1: invert here, carry-in comes from the preload
                  b_q     <= mode ? ~bus.ui_in[4+WIDTH-1:4] : bus.ui_in[4+WIDTH-1:4];
                  mode_q  <= mode;
                  carry_q <= mode;
                  cnt     <= '0;
               end
            end
            ST_RUN: begin
               sreg    <= sreg_nx;
               carry_q <= fa_cout;
               cnt     <= cnt + 1'b1;
               if (last) begin
                  res_q  <= sreg_nx;
                  flag_q <= mode_q ? ~fa_cout : fa_cout;
                  ovf_q  <= carry_q ^ fa_cout;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.uo_out  = {ovf_q, state == ST_DONE, state == ST_RUN, flag_q, 4'(res_q)};
   assign bus.uio_out = 8'h00;
   assign bus.uio_oe  = 8'h00;
   assign unused_in   = ^{bus.ui_in, bus.uio_in[7:2]};
endmodule

// File: tb/tb_tt_um_serial_adder.sv
// tb/tb_tt_um_serial_adder.sv - directed and exhaustive checks for tt_um_serial_adder
module tb_tt_um_serial_adder;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b0;
   logic [7:0] ui_in = 8'h00;
   logic       start = 1'b0;
   logic       mode = 1'b0;
   int         n_asserts = 0;
   int         n_fail = 0;

   always #5 clk = ~clk;

   tt_serial_adder_if bus1 ();
   tt_serial_adder_if bus2 ();
   tt_serial_adder_if bus3 ();
   tt_serial_adder_if bus4 ();

   assign bus1.ena = ena; assign bus1.ui_in = ui_in; assign bus1.uio_in = {6'b0, mode, start};
   assign bus2.ena = ena; assign bus2.ui_in = ui_in; assign bus2.uio_in = {6'b0, mode, start};
   assign bus3.ena = ena; assign bus3.ui_in = ui_in; assign bus3.uio_in = {6'b0, mode, start};
   assign bus4.ena = ena; assign bus4.ui_in = ui_in; assign bus4.uio_in = {6'b0, mode, start};

   tt_um_serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
   tt_um_serial_adder #(.WIDTH(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
   tt_um_serial_adder #(.WIDTH(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));
   tt_um_serial_adder #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

   logic [7:0] uo [1:4];
   assign uo[1] = bus1.uo_out;
   assign uo[2] = bus2.uo_out;
   assign uo[3] = bus3.uo_out;
   assign uo[4] = bus4.uo_out;

   logic [7:0] uio_all;
   assign uio_all = bus1.uio_out | bus1.uio_oe | bus2.uio_out | bus2.uio_oe |
                    bus3.uio_out | bus3.uio_oe | bus4.uio_out | bus4.uio_oe;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_asserts++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic go(input logic [3:0] a, input logic [3:0] b, input logic m);
      ui_in = {b, a};
      mode  = m;
      start = 1'b1;
   endtask

   // Arithmetic reference: expected uo_out in DONE for a w-bit operation
   function automatic logic [7:0] model(input int w, input int a, input int b, input bit sub);
      int mask, aw, bx, full, r, co, sa, sb, sr;
      bit ovf, cf;
      mask = (1 << w) - 1;
      aw   = a & mask;
      bx   = sub ? (~(b & mask) & mask) : (b & mask);
      full = aw + bx + (sub ? 1 : 0);
      r    = full & mask;
      co   = (full >> w) & 1;
      sa   = (aw >> (w - 1)) & 1;
      sb   = (bx >> (w - 1)) & 1;
      sr   = (r >> (w - 1)) & 1;
      ovf  = (sa == sb) && (sr != sa);
      cf   = sub ? (co == 0) : (co == 1);
      return {ovf, 1'b1, 1'b0, cf, 4'(r)};
   endfunction

   initial begin
      // Reset state
      tick(2);
      check("reset_uo", uo[4], 8'h00);
      check("reset_uio", uio_all, 8'h00);
      rst_n = 1'b1;
      ena   = 1'b1;
      tick();
      check("idle_uo", uo[4], 8'h00);

      // 5+3: busy through four RUN edges, result regs untouched until the last
      go(4'd5, 4'd3, 1'b0);
      tick();
      start = 1'b0;
      check("lat_k", uo[4], 8'h20);
      for (int i = 1; i < 4; i++) begin
         tick();
         check($sformatf("lat_k%0d", i), uo[4], 8'h20);
      end
      tick();
      check("add_5_3", uo[4], 8'hC8);
      tick(2);
      check("done_hold", uo[4], 8'hC8);

      // Directed add/sub table
      go(4'd7, 4'd9, 1'b0); tick(); start = 1'b0; tick(4);
      check("add_7_9", uo[4], 8'h50);
      go(4'd3, 4'd5, 1'b1); tick(); start = 1'b0; tick(4);
      check("sub_3_5", uo[4], 8'h5E);
      go(4'd8, 4'd1, 1'b1); tick(); start = 1'b0; tick(4);
      check("sub_8_1", uo[4], 8'hC7);

      // Start held through RUN with new operands, then back-to-back from DONE
      go(4'd5, 4'd3, 1'b0); tick();
      ui_in = {4'd9, 4'd7};
      check("held_run", uo[4], 8'hA7 | 8'h20);
      tick(3);
      check("held_run3", uo[4], 8'hA7);
      tick();
      check("held_first", uo[4], 8'hC8);
      tick();
      start = 1'b0;
      check("b2b_start", uo[4], 8'hA8);
      tick(4);
      check("b2b_second", uo[4], 8'h50);

      // Reset mid-RUN, with start asserted in the same edge
      go(4'd5, 4'd3, 1'b0); tick(); start = 1'b0;
      tick();
      rst_n = 1'b0;
      go(4'd3, 4'd5, 1'b1);
      tick();
      check("rst_mid_run", uo[4], 8'h00);
      rst_n = 1'b1;
      tick();
      start = 1'b0;
      check("rst_restart", uo[4], 8'h20);
      tick(4);
      check("rst_result", uo[4], 8'h5E);

      // Enable stall mid-RUN
      go(4'd8, 4'd1, 1'b1); tick(); start = 1'b0;
      tick();
      ena = 1'b0;
      tick(3);
      check("stall_hold", uo[4], 8'h3E);
      check("stall_uio", uio_all, 8'h00);
      ena = 1'b1;
      tick(2);
      check("stall_late", uo[4], 8'h3E);
      tick();
      check("stall_done", uo[4], 8'hC7);

      // Start ignored while disabled in DONE
      ena = 1'b0;
      go(4'd1, 4'd1, 1'b0);
      tick(2);
      check("ena0_start", uo[4], 8'hC7);
      start = 1'b0;
      ena   = 1'b1;
      tick(4);

      // Exhaustive sweep over every width, operand pair and mode
      for (int m = 0; m < 2; m++) begin
         for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
               go(4'(a), 4'(b), 1'(m));
               tick();
               start = 1'b0;
               tick(4);
               for (int w = 1; w <= 4; w++)
                  check($sformatf("sweep_w%0d_a%0d_b%0d_m%0d", w, a, b, m), uo[w], model(w, a, b, m[0]));
            end
         end
      end
      check("final_uio", uio_all, 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end
endmodule
